// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine issuing one valid/ready data-memory request per op.
// Build option: define MISALIGN_CHECK_EN to fault misaligned halfword/word accesses without a bus request.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_valid,
    input  logic              ex_mem_we,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              lsu_stall,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_fault,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic [ADDR_W-1:0] dm_req_addr,
    output logic              dm_req_we,
    output logic [3:0]        dm_req_wstrb,
    output logic [31:0]       dm_req_wdata,
    input  logic              dm_resp_valid,
    input  logic [31:0]       dm_resp_rdata,
    input  logic              dm_resp_err
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          lane_q, lane_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                req_valid_q, req_valid_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                is_byte_c, is_half_c, misalign_c;
    logic [STRB_W-1:0]   store_strb_c;
    logic [DATA_W-1:0]   store_wdata_c;
    logic [7:0]          load_byte_c;
    logic [15:0]         load_half_c;
    logic [DATA_W-1:0]   load_ext_c;

    // Access size from funct3[1:0]; encodings 10/11 are word-sized.
    assign is_byte_c = (ex_funct3[1:0] == 2'b00);
    assign is_half_c = (ex_funct3[1:0] == 2'b01);

`ifdef MISALIGN_CHECK_EN
    assign misalign_c = (is_half_c & ex_addr[0]) |
                        (~is_byte_c & ~is_half_c & (ex_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    always_comb begin
        store_strb_c  = 4'b1111;
        store_wdata_c = ex_wdata;
        if (is_byte_c) begin
            store_strb_c  = 4'b0001 << ex_addr[1:0];
            store_wdata_c = {4{ex_wdata[7:0]}};
        end else if (is_half_c) begin
            store_strb_c  = ex_addr[1] ? 4'b1100 : 4'b0011;
            store_wdata_c = {2{ex_wdata[15:0]}};
        end
    end

    // Lane extraction and sign/zero extension of the returned word.
    always_comb begin
        case (lane_q)
            2'd0:    load_byte_c = dm_resp_rdata[7:0];
            2'd1:    load_byte_c = dm_resp_rdata[15:8];
            2'd2:    load_byte_c = dm_resp_rdata[23:16];
            default: load_byte_c = dm_resp_rdata[31:24];
        endcase
        load_half_c = lane_q[1] ? dm_resp_rdata[31:16] : dm_resp_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext_c = {{24{load_byte_c[7] & ~funct3_q[2]}}, load_byte_c};
            2'b01:   load_ext_c = {{16{load_half_c[15] & ~funct3_q[2]}}, load_half_c};
            default: load_ext_c = dm_resp_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        req_valid_d = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (ex_mem_valid) begin
                    we_d     = ex_mem_we;
                    funct3_d = ex_funct3;
                    lane_d   = ex_addr[1:0];
                    addr_d   = {ex_addr[ADDR_W-1:2], 2'b00};
                    wstrb_d  = ex_mem_we ? store_strb_c : '0;
                    wdata_d  = store_wdata_c;
                    if (misalign_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (dm_req_ready) begin
                    state_d = S_RESP;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            S_RESP: begin
                if (dm_resp_valid) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = dm_resp_err;
                    if (!we_q && !dm_resp_err) begin
                        rdata_d = load_ext_c;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            lane_q      <= '0;
            addr_q      <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            req_valid_q <= req_valid_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
        end
    end

    // Stall is combinational so a newly presented op freezes the pipe in its first cycle.
    assign lsu_stall    = (state_q != S_DONE) & (ex_mem_valid | (state_q != S_IDLE));
    assign lsu_done     = done_q;
    assign lsu_fault    = fault_q;
    assign lsu_rdata    = rdata_q;
    assign dm_req_valid = req_valid_q;
    assign dm_req_addr  = addr_q;
    assign dm_req_we    = we_q;
    assign dm_req_wstrb = wstrb_q;
    assign dm_req_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table, hand sequences and randomized ops against a reference model.
module tb_mem_access_unit;
    localparam int unsigned ADDR_W = 32;
    localparam int BUDGET = 60;
    localparam int N_VEC  = 14;
    localparam int N_RND  = 150;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_mem_valid, ex_mem_we;
    logic [2:0]        ex_funct3;
    logic [ADDR_W-1:0] ex_addr;
    logic [31:0]       ex_wdata;
    logic              lsu_stall, lsu_done, lsu_fault;
    logic [31:0]       lsu_rdata;
    logic              dm_req_valid, dm_req_ready, dm_req_we;
    logic [ADDR_W-1:0] dm_req_addr;
    logic [3:0]        dm_req_wstrb;
    logic [31:0]       dm_req_wdata;
    logic              dm_resp_valid, dm_resp_err;
    logic [31:0]       dm_resp_rdata;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rdy_wait;
        int          resp_wait;
        logic        stray;
        logic [31:0] word;
        logic        err;
    } op_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        int          done_cyc;
        logic        issues;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t exp;
    } vec_t;

    typedef struct {
        int          done_cyc;
        logic        fault;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          nreq;
        logic        stall_bad;
        logic        unstable;
        logic        stray_pulse;
    } obs_t;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_valid(ex_mem_valid), .ex_mem_we(ex_mem_we), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_fault(lsu_fault),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
        .dm_req_we(dm_req_we), .dm_req_wstrb(dm_req_wstrb), .dm_req_wdata(dm_req_wdata),
        .dm_resp_valid(dm_resp_valid), .dm_resp_rdata(dm_resp_rdata), .dm_resp_err(dm_resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: access size, lane offset and extension derived arithmetically from funct3/address.
    function automatic exp_t model(input op_t op, input logic [31:0] held);
        exp_t            e;
        int              size;
        int              off;
        logic            sgn;
        logic            mis;
        longint unsigned mask;
        longint unsigned val;
        case (op.f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        sgn = (op.f3 == 3'd0) || (op.f3 == 3'd1);
        off = (size == 1) ? int'(op.addr % 4) : (size == 2) ? (int'(op.addr % 4) / 2) * 2 : 0;
        mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
        mis = (int'(op.addr % 4) % size) != 0;
`endif
        mask   = (64'd1 << (8 * size)) - 64'd1;
        e.addr = op.addr & 32'hFFFF_FFFC;
        e.strb = op.we ? 4'(((1 << size) - 1) << off) : 4'd0;
        case (size)
            1:       e.wdata = (op.wdata & 32'h0000_00FF) * 32'h0101_0101;
            2:       e.wdata = (op.wdata & 32'h0000_FFFF) * 32'h0001_0001;
            default: e.wdata = op.wdata;
        endcase
        val = (64'(op.word) >> (8 * off)) & mask;
        if (sgn && val[8 * size - 1]) val = val | ~mask;
        e.issues   = !mis;
        e.fault    = mis || op.err;
        e.done_cyc = mis ? 1 : 3 + op.rdy_wait + op.resp_wait;
        e.rdata    = (!op.we && !e.fault) ? val[31:0] : held;
        return e;
    endfunction

    // Drives one op as pipeline + memory responder and records what the DUT did.
    task automatic run_op(input op_t op, output obs_t ob);
        bit seen_req, accepted, responded, done_seen;
        int rdy_cnt, resp_cnt;
        seen_req = 0; accepted = 0; responded = 0; done_seen = 0;
        rdy_cnt = 0; resp_cnt = 0;
        ob.done_cyc = -1; ob.fault = 0; ob.rdata = '0; ob.addr = '0; ob.we = 0;
        ob.strb = '0; ob.wdata = '0; ob.nreq = 0; ob.stall_bad = 0; ob.unstable = 0;
        ob.stray_pulse = 0;
        @(negedge clk);
        ex_mem_valid = 1'b1; ex_mem_we = op.we; ex_funct3 = op.f3;
        ex_addr = op.addr; ex_wdata = op.wdata;
        for (int c = 0; c < BUDGET && !done_seen; c++) begin
            if (c != 0) @(negedge clk);
            dm_req_ready  = 1'b0;
            dm_resp_valid = 1'b0;
            dm_resp_err   = 1'b0;
            dm_resp_rdata = $urandom;
            #1;
            if (lsu_done) begin
                done_seen   = 1;
                ob.done_cyc = c;
                ob.fault    = lsu_fault;
                ob.rdata    = lsu_rdata;
                if (lsu_stall) ob.stall_bad = 1;
            end else begin
                if (!lsu_stall) ob.stall_bad = 1;
                if (lsu_fault) ob.stray_pulse = 1;
            end
            if (!done_seen) begin
                if (accepted && !responded) begin
                    if (resp_cnt >= op.resp_wait) begin
                        dm_resp_valid = 1'b1; dm_resp_rdata = op.word; dm_resp_err = op.err;
                        responded = 1;
                    end else begin
                        resp_cnt++;
                    end
                end
                if (dm_req_valid) begin
                    if (!seen_req) begin
                        ob.addr = dm_req_addr; ob.we = dm_req_we;
                        ob.strb = dm_req_wstrb; ob.wdata = dm_req_wdata;
                    end else if (ob.addr !== dm_req_addr || ob.we !== dm_req_we ||
                                 ob.strb !== dm_req_wstrb || ob.wdata !== dm_req_wdata) begin
                        ob.unstable = 1;
                    end
                    seen_req = 1;
                    if (rdy_cnt >= op.rdy_wait) begin
                        dm_req_ready = 1'b1; ob.nreq++; accepted = 1;
                    end else begin
                        rdy_cnt++;
                        if (op.stray) begin
                            dm_resp_valid = 1'b1; dm_resp_rdata = ~op.word; dm_resp_err = !op.err;
                        end
                    end
                end
            end
        end
        // ex_mem_valid stayed high through the done cycle; it must not have been captured there.
        @(negedge clk);
        ex_mem_valid = 1'b0; dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
        #1;
        chk("idle_after.req_valid", 32'(dm_req_valid), 32'd0);
        chk("idle_after.done", 32'(lsu_done), 32'd0);
    endtask

    task automatic check_op(input string tag, input op_t op, input exp_t e);
        obs_t ob;
        run_op(op, ob);
        chk({tag, ".done_cyc"}, 32'(ob.done_cyc), 32'(e.done_cyc));
        chk({tag, ".fault"}, 32'(ob.fault), 32'(e.fault));
        chk({tag, ".rdata"}, ob.rdata, e.rdata);
        chk({tag, ".stall"}, 32'(ob.stall_bad), 32'd0);
        chk({tag, ".stray_fault"}, 32'(ob.stray_pulse), 32'd0);
        chk({tag, ".nreq"}, 32'(ob.nreq), e.issues ? 32'd1 : 32'd0);
        if (e.issues) begin
            chk({tag, ".stable"}, 32'(ob.unstable), 32'd0);
            chk({tag, ".addr"}, ob.addr, e.addr);
            chk({tag, ".we"}, 32'(ob.we), 32'(op.we));
            chk({tag, ".strb"}, 32'(ob.strb), 32'(e.strb));
            if (op.we) chk({tag, ".wdata"}, ob.wdata, e.wdata);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int rw, input int pw,
                                input logic [31:0] word, input logic err,
                                input logic [31:0] eaddr, input logic [3:0] estrb,
                                input logic [31:0] ewdata, input logic [31:0] erdata,
                                input logic efault, input int edone);
        vec_t v;
        v.op.we = we; v.op.f3 = f3; v.op.addr = addr; v.op.wdata = wdata;
        v.op.rdy_wait = rw; v.op.resp_wait = pw; v.op.stray = 1'b0;
        v.op.word = word; v.op.err = err;
        v.exp.addr = eaddr; v.exp.strb = estrb; v.exp.wdata = ewdata; v.exp.rdata = erdata;
        v.exp.fault = efault; v.exp.done_cyc = edone; v.exp.issues = 1'b1;
        return v;
    endfunction

    vec_t        tbl [N_VEC];
    logic [31:0] held;

    initial begin
        op_t  op;
        exp_t e;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        ex_mem_valid = 0; ex_mem_we = 0; ex_funct3 = '0; ex_addr = '0; ex_wdata = '0;
        dm_req_ready = 0; dm_resp_valid = 0; dm_resp_rdata = '0; dm_resp_err = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.stall", 32'(lsu_stall), 32'd0);
        chk("reset.done", 32'(lsu_done), 32'd0);
        chk("reset.fault", 32'(lsu_fault), 32'd0);
        chk("reset.rdata", lsu_rdata, 32'd0);
        chk("reset.req_valid", 32'(dm_req_valid), 32'd0);
        chk("reset.req_addr", dm_req_addr, 32'd0);
        chk("reset.req_strb", 32'(dm_req_wstrb), 32'd0);
        chk("reset.req_wdata", dm_req_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // we f3 addr wdata rdy resp word err | addr strb wdata rdata fault done
        tbl[0]  = mk(0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF, 0, 3);
        tbl[1]  = mk(1, 3'd0, 32'h203, 32'hA5, 0, 0, 32'h11111111, 0, 32'h200, 4'h8, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 3);
        tbl[2]  = mk(0, 3'd0, 32'h001, 32'h0, 0, 0, 32'h0000F000, 0, 32'h000, 4'h0, 32'h0, 32'hFFFFFFF0, 0, 3);
        tbl[3]  = mk(0, 3'd4, 32'h001, 32'h0, 0, 0, 32'h0000F000, 0, 32'h000, 4'h0, 32'h0, 32'h000000F0, 0, 3);
        tbl[4]  = mk(0, 3'd1, 32'h002, 32'h0, 0, 0, 32'h80000000, 0, 32'h000, 4'h0, 32'h0, 32'hFFFF8000, 0, 3);
        tbl[5]  = mk(0, 3'd5, 32'h002, 32'h0, 0, 0, 32'h80000000, 0, 32'h000, 4'h0, 32'h0, 32'h00008000, 0, 3);
        tbl[6]  = mk(0, 3'd2, 32'h040, 32'h0, 5, 0, 32'h12345678, 0, 32'h040, 4'h0, 32'h0, 32'h12345678, 0, 8);
        tbl[7]  = mk(0, 3'd2, 32'h044, 32'h0, 0, 0, 32'hCAFEF00D, 1, 32'h044, 4'h0, 32'h0, 32'h12345678, 1, 3);
        tbl[8]  = mk(1, 3'd1, 32'h106, 32'h1234ABCD, 0, 1, 32'h0, 0, 32'h104, 4'hC, 32'hABCDABCD, 32'h12345678, 0, 4);
        tbl[9]  = mk(1, 3'd2, 32'h10C, 32'h01020304, 2, 0, 32'h0, 0, 32'h10C, 4'hF, 32'h01020304, 32'h12345678, 0, 5);
        tbl[10] = mk(0, 3'd3, 32'h020, 32'h0, 0, 2, 32'h55AA55AA, 0, 32'h020, 4'h0, 32'h0, 32'h55AA55AA, 0, 5);
        tbl[11] = mk(1, 3'd0, 32'h000, 32'hFFFFFF7E, 0, 0, 32'h0, 1, 32'h000, 4'h1, 32'h7E7E7E7E, 32'h55AA55AA, 1, 3);
        tbl[12] = mk(0, 3'd0, 32'h003, 32'h0, 0, 0, 32'h80FFFFFF, 0, 32'h000, 4'h0, 32'h0, 32'hFFFFFF80, 0, 3);
        tbl[13] = mk(0, 3'd6, 32'h008, 32'h0, 0, 0, 32'h0BADF00D, 0, 32'h008, 4'h0, 32'h0, 32'h0BADF00D, 0, 3);
        tbl[6].op.stray = 1'b1;
        for (int i = 0; i < N_VEC; i++) begin
            check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].exp);
        end
        held = tbl[N_VEC-1].exp.rdata;

        // Misaligned word store and halfword load.
        op = tbl[9].op; op.addr = 32'h102; op.wdata = 32'hA1B2C3D4; op.rdy_wait = 0;
        e.rdata = held; e.addr = 32'h100; e.strb = 4'hF; e.wdata = 32'hA1B2C3D4;
`ifdef MISALIGN_CHECK_EN
        e.issues = 0; e.fault = 1; e.done_cyc = 1;
`else
        e.issues = 1; e.fault = 0; e.done_cyc = 3;
`endif
        check_op("mis_sw", op, e);
        op = tbl[4].op; op.addr = 32'h101; op.word = 32'h00008001;
        e.addr = 32'h100; e.strb = 4'h0; e.wdata = 32'h0;
`ifdef MISALIGN_CHECK_EN
        e.issues = 0; e.fault = 1; e.done_cyc = 1; e.rdata = held;
`else
        e.issues = 1; e.fault = 0; e.done_cyc = 3; e.rdata = 32'hFFFF8001;
`endif
        check_op("mis_lh", op, e);
        held = e.rdata;

        for (int i = 0; i < N_RND; i++) begin
            logic [2:0] st_f3 [6];
            st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
            op.we        = 1'($urandom_range(0, 1));
            op.f3        = op.we ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            op.addr      = $urandom;
            op.wdata     = $urandom;
            op.rdy_wait  = $urandom_range(0, 3);
            op.resp_wait = $urandom_range(0, 3);
            op.stray     = 1'($urandom_range(0, 1));
            op.word      = $urandom;
            op.err       = ($urandom_range(0, 7) == 0);
            e = model(op, held);
            check_op($sformatf("rnd%0d", i), op, e);
            held = e.rdata;
        end

        // Reset while a request is pending: valid drops without a clock edge.
        @(negedge clk);
        ex_mem_valid = 1; ex_mem_we = 0; ex_funct3 = 3'd2; ex_addr = 32'h80; dm_req_ready = 0;
        @(negedge clk);
        #1;
        chk("rst_req.valid_before", 32'(dm_req_valid), 32'd1);
        ex_mem_valid = 0;
        rst = 1'b1;
        #1;
        chk("rst_req.valid_async", 32'(dm_req_valid), 32'd0);
        chk("rst_req.stall", 32'(lsu_stall), 32'd0);
        chk("rst_req.rdata", lsu_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in RESP, then a late response must be ignored.
        @(negedge clk);
        ex_mem_valid = 1; ex_addr = 32'h84; dm_req_ready = 1;
        @(negedge clk);
        @(negedge clk);
        ex_mem_valid = 0; dm_req_ready = 0;
        #1;
        chk("rst_resp.stall_before", 32'(lsu_stall), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dm_resp_valid = 1; dm_resp_rdata = 32'h77777777; dm_resp_err = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rst_resp.done%0d", c), 32'(lsu_done), 32'd0);
            chk($sformatf("rst_resp.stall%0d", c), 32'(lsu_stall), 32'd0);
            chk($sformatf("rst_resp.req%0d", c), 32'(dm_req_valid), 32'd0);
            chk($sformatf("rst_resp.rdata%0d", c), lsu_rdata, 32'd0);
            @(negedge clk);
            dm_resp_valid = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
